// File: rtl/clk_gate_ctrl_mc.sv
// clk_gate_ctrl_mc: multi-channel idle-driven clock gating controller.
// Each channel runs an independent RUN/COUNT/GATED/WAKE FSM. The gate enable
// is registered and captured by a clk-low transparent latch, so clk_out
// only changes while clk is low and cannot glitch.
// Optional feature: define CLK_GATE_CTRL_TEST_BYPASS_EN to add a test_en
// input that forces every latch open (clk_out = clk) without touching the FSMs.
module clk_gate_ctrl_mc #(
   parameter int NUM_CH   = 4,
   parameter int CNT_W    = 8,
   parameter int WAKE_DLY = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] busy,
   input  logic [NUM_CH-1:0] auto_en,
   input  logic [NUM_CH-1:0] force_on,
   input  logic [CNT_W-1:0]  idle_thresh,
`ifdef CLK_GATE_CTRL_TEST_BYPASS_EN
   input  logic              test_en,
`endif
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] ch_on,
   output logic              all_gated
);

   typedef enum logic [1:0] {RUN, COUNT, GATED, WAKE} state_t;

   // Last wake-counter value before returning to RUN.
   localparam logic [3:0] WAKE_LAST = 4'((WAKE_DLY > 0) ? WAKE_DLY - 1 : 0);

   logic [NUM_CH-1:0] gated_now;
   logic [NUM_CH-1:0] gated_next;
   logic              bypass;

`ifdef CLK_GATE_CTRL_TEST_BYPASS_EN
   assign bypass = test_en;
`else
   assign bypass = 1'b0;
`endif

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      state_t           state, state_n;
      logic [CNT_W-1:0] cnt, cnt_n;
      logic [3:0]       wcnt, wcnt_n;
      logic             wake;
      logic             en_q;
      logic             on_q;
      logic             en_lat;

      assign wake = busy[i] | force_on[i] | ~auto_en[i] | (idle_thresh == '0);

      // Next-state and counter update for this channel.
      always_comb begin
         state_n = state;
         cnt_n   = cnt;
         wcnt_n  = wcnt;
         case (state)
            RUN: begin
               if (wake) begin
                  cnt_n = '0;
               end else begin
                  state_n = COUNT;
                  cnt_n   = CNT_W'(1);
               end
            end
            COUNT: begin
               // Wake beats threshold; >= covers a threshold lowered mid-count.
               if (wake) begin
                  state_n = RUN;
                  cnt_n   = '0;
               end else if (cnt >= idle_thresh) begin
                  state_n = GATED;
               end else if (cnt != '1) begin
                  cnt_n = cnt + 1'b1;
               end
            end
            GATED: begin
               if (wake) begin
                  if (WAKE_DLY == 0) begin
                     state_n = RUN;
                     cnt_n   = '0;
                  end else begin
                     state_n = WAKE;
                     wcnt_n  = '0;
                  end
               end
            end
            WAKE: begin
               if (wcnt == WAKE_LAST) begin
                  state_n = RUN;
                  cnt_n   = '0;
               end else begin
                  wcnt_n = wcnt + 1'b1;
               end
            end
            default: begin
               state_n = RUN;
               cnt_n   = '0;
               wcnt_n  = '0;
            end
         endcase
      end

      // State, counters, gate enable and status registers.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
            wcnt  <= '0;
            en_q  <= 1'b1;
            on_q  <= 1'b1;
         end else begin
            state <= state_n;
            cnt   <= cnt_n;
            wcnt  <= wcnt_n;
            en_q  <= (state_n != GATED);
            on_q  <= (state_n == RUN) || (state_n == COUNT);
         end
      end

      // Enable capture while clk is low keeps clk_out glitch-free.
      always_latch begin
         if (!clk) en_lat = en_q | bypass;
      end

      assign clk_out[i]    = clk & en_lat;
      assign ch_on[i]      = on_q;
      assign gated_now[i]  = (state == GATED);
      assign gated_next[i] = (state_n == GATED);
   end

   // Asserts one cycle after the last channel gates; drops on the edge any leaves.
   always_ff @(posedge clk) begin
      if (!rst_n) all_gated <= 1'b0;
      else        all_gated <= (&gated_now) & (&gated_next);
   end

endmodule

// File: tb/tb_clk_gate_ctrl_mc.sv
// tb_clk_gate_ctrl_mc: directed + randomized bench for clk_gate_ctrl_mc with a
// behavioural per-channel model (idle run length, gated flag, wake countdown).
// Set CLK_GATE_CTRL_TEST_BYPASS_EN to also exercise the test_en bypass.
module tb_clk_gate_ctrl_mc;
   localparam int NUM_CH   = 4;
   localparam int CNT_W    = 8;
   localparam int WAKE_DLY = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NUM_CH-1:0] busy, auto_en, force_on;
   logic [CNT_W-1:0]  idle_thresh;
   logic              test_en;
   logic [NUM_CH-1:0] clk_out, ch_on;
   logic              all_gated;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 0;

   // reference model state
   int idle  [NUM_CH];
   bit gated [NUM_CH];
   int wleft [NUM_CH];
   bit exp_ag;
   logic [NUM_CH-1:0] prev_en;

   always #5 clk = ~clk;

   clk_gate_ctrl_mc #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .WAKE_DLY(WAKE_DLY)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .busy(busy),
      .auto_en(auto_en),
      .force_on(force_on),
      .idle_thresh(idle_thresh),
`ifdef CLK_GATE_CTRL_TEST_BYPASS_EN
      .test_en(test_en),
`endif
      .clk_out(clk_out),
      .ch_on(ch_on),
      .all_gated(all_gated)
   );

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
      end
   endtask

   function automatic logic [NUM_CH-1:0] model_en();
      logic [NUM_CH-1:0] v;
      for (int c = 0; c < NUM_CH; c++) v[c] = !gated[c];
      return v;
   endfunction

   function automatic logic [NUM_CH-1:0] model_on();
      logic [NUM_CH-1:0] v;
      for (int c = 0; c < NUM_CH; c++) v[c] = !gated[c] && (wleft[c] == 0);
      return v;
   endfunction

   // Advance the model by one rising edge using the inputs currently applied.
   task automatic model_edge();
      bit all_before = 1;
      bit all_after  = 1;
      bit w;
      for (int c = 0; c < NUM_CH; c++) all_before &= gated[c];
      prev_en = model_en();
      if (!rst_n) begin
         for (int c = 0; c < NUM_CH; c++) begin
            idle[c] = 0; gated[c] = 0; wleft[c] = 0;
         end
         exp_ag = 0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            w = busy[c] | force_on[c] | ~auto_en[c] | (idle_thresh == 0);
            if (wleft[c] > 0) begin
               wleft[c]--;
            end else if (gated[c]) begin
               if (w) begin
                  gated[c] = 0; idle[c] = 0; wleft[c] = WAKE_DLY;
               end
            end else if (w) begin
               idle[c] = 0;
            end else if (idle[c] > 0 && idle[c] >= int'(idle_thresh)) begin
               gated[c] = 1;
            end else if (idle[c] < 255) begin
               idle[c]++;
            end
         end
         for (int c = 0; c < NUM_CH; c++) all_after &= gated[c];
         exp_ag = all_before && all_after;
      end
   endtask

   task automatic step();
      logic [NUM_CH-1:0] exp_clk;
      @(posedge clk);
      model_edge();
      exp_clk = prev_en | {NUM_CH{test_en}};
      #1;
      if (chk_en) begin
         check_vec("clk_out_high", 32'(clk_out), 32'(exp_clk));
         check_vec("ch_on", 32'(ch_on), 32'(model_on()));
         check_vec("all_gated", 32'(all_gated), 32'(exp_ag));
      end
      @(negedge clk);
      #1;
      if (chk_en) check_vec("clk_out_low", 32'(clk_out), 32'd0);
   endtask

   initial begin
      for (int c = 0; c < NUM_CH; c++) begin
         idle[c] = 0; gated[c] = 0; wleft[c] = 0;
      end
      exp_ag = 0;
      prev_en = '1;
      rst_n = 0; busy = '0; auto_en = '1; force_on = '0;
      idle_thresh = 8'd3; test_en = 1'b0;

      // reset state
      step();
      chk_en = 1;
      step();
      step();

      // all channels idle with threshold 3: gate, then all_gated
      rst_n = 1;
      for (int k = 0; k < 10; k++) step();

      // single-cycle wake of channel 1 only
      busy = 4'b0010;
      step();
      busy = '0;
      for (int k = 0; k < 8; k++) step();

      // reset while gated restarts clocks
      rst_n = 0;
      step();
      rst_n = 1;

      // wake pulse on the threshold edge keeps channel 0 running
      for (int k = 0; k < 3; k++) step();
      busy = 4'b0001;
      step();
      busy = '0;
      for (int k = 0; k < 8; k++) step();

      // threshold 0 never gates
      idle_thresh = '0;
      for (int k = 0; k < 300; k++) step();

      // force_on never gates
      idle_thresh = 8'd3;
      force_on = '1;
      for (int k = 0; k < 60; k++) step();
      force_on = '0;
      for (int k = 0; k < 8; k++) step();

`ifdef CLK_GATE_CTRL_TEST_BYPASS_EN
      // bypass while everything is gated
      test_en = 1'b1;
      for (int k = 0; k < 4; k++) step();
      test_en = 1'b0;
      for (int k = 0; k < 3; k++) step();
`endif

      // randomized traffic
      for (int k = 0; k < 1500; k++) begin
         for (int c = 0; c < NUM_CH; c++) begin
            busy[c]     = ($urandom_range(0, 9) == 0);
            auto_en[c]  = ($urandom_range(0, 15) != 0);
            force_on[c] = ($urandom_range(0, 31) == 0);
         end
         if ($urandom_range(0, 19) == 0) idle_thresh = 8'($urandom_range(0, 6));
         rst_n = ($urandom_range(0, 199) != 0);
`ifdef CLK_GATE_CTRL_TEST_BYPASS_EN
         test_en = ($urandom_range(0, 9) == 0);
`endif
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
